// File: rtl/tdm_demultiplexer_1by8.sv
// One-bit to eight-bit TDM demultiplexer: addressed single-bit routing, or
// auto-scan framing where eight valid bits are collected and published atomically.
module tdm_demultiplexer_1by8 (
  input  logic clk,
  input  logic rst,
  input  logic D,
  input  logic V,
  input  logic M,
  input  logic S0,
  input  logic S1,
  input  logic S2,
  output logic Y0,
  output logic Y1,
  output logic Y2,
  output logic Y3,
  output logic Y4,
  output logic Y5,
  output logic Y6,
  output logic Y7,
  output logic DONE,
  output logic BUSY,
  output logic C0,
  output logic C1,
  output logic C2
);

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t     r_state;
  logic [2:0] r_slot;
  logic [7:0] r_shadow;
  logic [7:0] r_y;
  logic       r_done;

  state_t     w_state_nxt;
  logic [2:0] w_slot_nxt;
  logic [7:0] w_shadow_nxt;
  logic [7:0] w_y_nxt;
  logic       w_done_nxt;
  logic [2:0] w_idx;

  assign w_idx = {S2, S1, S0};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_slot   <= 3'd0;
      r_shadow <= 8'd0;
      r_y      <= 8'd0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_slot   <= w_slot_nxt;
      r_shadow <= w_shadow_nxt;
      r_y      <= w_y_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // Leaving auto-scan abandons any partial frame; the addressed write still lands.
  always_comb begin
    w_state_nxt  = r_state;
    w_slot_nxt   = r_slot;
    w_shadow_nxt = r_shadow;
    w_y_nxt      = r_y;
    w_done_nxt   = 1'b0;
    if (!M) begin
      w_state_nxt = IDLE;
      w_slot_nxt  = 3'd0;
      if (V) w_y_nxt[w_idx] = D;
    end else if (V) begin
      case (r_state)
        IDLE: begin
          w_shadow_nxt[0] = D;
          w_slot_nxt      = 3'd1;
          w_state_nxt     = FILL;
        end
        FILL: begin
          w_shadow_nxt[r_slot] = D;
          if (r_slot == 3'd7) begin
            // Final bit bypasses the shadow so the frame publishes on this edge.
            w_y_nxt     = {D, r_shadow[6:0]};
            w_done_nxt  = 1'b1;
            w_slot_nxt  = 3'd0;
            w_state_nxt = IDLE;
          end else begin
            w_slot_nxt = r_slot + 3'd1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_slot_nxt  = 3'd0;
        end
      endcase
    end
  end

  assign {Y7, Y6, Y5, Y4, Y3, Y2, Y1, Y0} = r_y;
  assign DONE         = r_done;
  assign BUSY         = (r_state == FILL);
  assign {C2, C1, C0} = r_slot;

endmodule
